// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset datapath: one shared ALU and one req/ack memory port for fetch and data.
// Define MC_DP_PERF_EN to add the perf_cycles / perf_retired counters.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        retire,
  output logic        illegal,
  output logic [2:0]  state_dbg
`ifdef MC_DP_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_retired
`endif
);

  localparam int unsigned RW = $clog2(NREGS);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] regs [NREGS];

  logic [5:0]    op, funct, alu_fn;
  logic [RW-1:0] rs_i, rt_i, rd_i, wr_i;
  logic [31:0]   sext, alu_a, alu_b, alu_y, wr_data;
  logic          is_r, legal, done;

  assign op    = ir[31:26];
  assign funct = ir[5:0];
  assign rs_i  = ir[21 +: RW];
  assign rt_i  = ir[16 +: RW];
  assign rd_i  = ir[11 +: RW];
  assign sext  = {{16{ir[15]}}, ir[15:0]};
  assign is_r  = (op == OP_R);

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R:                                legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
  end

  // Shared ALU: PC+4 in FETCH, branch target in DECODE, operation/address in EXEC.
  always_comb begin
    alu_a  = pc;
    alu_b  = 32'd4;
    alu_fn = F_ADD;
    case (state)
      DECODE: alu_b = sext << 2;
      EXEC: begin
        alu_a = a;
        alu_b = is_r ? b : sext;
        if (is_r) alu_fn = funct;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_fn)
      F_SUB:   alu_y = alu_a - alu_b;
      F_AND:   alu_y = alu_a & alu_b;
      F_OR:    alu_y = alu_a | alu_b;
      F_SLT:   alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  assign wr_i    = is_r ? rd_i : rt_i;
  assign wr_data = (op == OP_LW) ? mdr : alu_out;

  // Completion is registered into retire, so mem_ack never reaches an output combinationally.
  assign done = ((state == EXEC) && ((op == OP_BEQ) || (op == OP_J))) ||
                ((state == MEM) && mem_ack && (op == OP_SW)) ||
                (state == WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      retire  <= 1'b0;
      illegal <= 1'b0;
      regs    <= '{default: '0};
    end else begin
      retire  <= done;
      illegal <= (state == DECODE) && !legal;
      case (state)
        FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            pc    <= alu_y;
            state <= DECODE;
          end
        end
        DECODE: begin
          a       <= regs[rs_i];
          b       <= regs[rt_i];
          alu_out <= alu_y;
          state   <= legal ? EXEC : FETCH;
        end
        EXEC: begin
          case (op)
            OP_R, OP_ADDI: begin
              alu_out <= alu_y;
              state   <= WB;
            end
            OP_LW, OP_SW: begin
              alu_out <= alu_y;
              state   <= MEM;
            end
            OP_BEQ: begin
              if (a == b) pc <= alu_out;
              state <= FETCH;
            end
            OP_J: begin
              pc    <= {pc[31:28], ir[25:0], 2'b00};
              state <= FETCH;
            end
            default: state <= FETCH;
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            if (op == OP_SW) begin
              state <= FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= WB;
            end
          end
        end
        WB: begin
          if (wr_i != '0) regs[wr_i] <= wr_data;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Gated by rst_n so the request and address collapse the moment reset asserts.
  assign mem_req   = rst_n && ((state == FETCH) || (state == MEM));
  assign mem_we    = rst_n && (state == MEM) && (op == OP_SW);
  assign mem_addr  = !rst_n ? '0 : ((state == MEM) ? {alu_out[31:2], 2'b00} : pc);
  assign mem_wdata = b;
  assign state_dbg = state;

`ifdef MC_DP_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
    end else begin
      perf_cycles <= perf_cycles + 32'd1;
      if (done) perf_retired <= perf_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Randomised bench for mc_datapath: an ISA-level interpreter predicts memory traffic,
// completion pulses and per-instruction cycle counts; the bench also acts as the memory.
module tb_mc_datapath;

  localparam int unsigned NREGS    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        retire, illegal;
  logic [2:0]  state_dbg;
`ifdef MC_DP_PERF_EN
  logic [31:0] perf_cycles, perf_retired;
`endif

  mc_datapath #(.RESET_PC(RESET_PC), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .retire(retire), .illegal(illegal), .state_dbg(state_dbg)
`ifdef MC_DP_PERF_EN
    , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0, errors = 0;
  logic [31:0] mem   [1024];   // words 0..511 code, 512..1023 data (DUT side)
  logic [31:0] rdmem [1024];   // reference data memory
  logic [31:0] rregs [32];
  logic [31:0] mpc;
  int unsigned t_prev, t_rel, nretired, total_lat, lat_max;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic serve(input string tag, input logic [31:0] addr, input logic we, input logic chk_wd,
                       input logic [31:0] wd, input logic [2:0] st, output logic [31:0] wseen);
    int unsigned lat;
    int n = 0;
    while (mem_req !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, mem_req, 1'b1);
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_we"}, mem_we, we);
    check({tag, "_state"}, state_dbg, st);
    if (chk_wd) check({tag, "_wdata"}, mem_wdata, wd);
    lat = $urandom_range(0, lat_max);
    total_lat += lat;
    for (int unsigned k = 0; k < lat; k++) begin
      @(negedge clk);
      check({tag, "_hold"}, {mem_req, mem_we, mem_addr}, {1'b1, we, addr});
    end
    wseen     = mem_wdata;
    mem_rdata = mem[addr[11:2]];
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (we) mem[addr[11:2]] = wseen;
  endtask

  task automatic run_instr(input logic [31:0] ins);
    logic [5:0]  op, fn;
    int unsigned rs, rt, rd, dest, base;
    logic [31:0] va, vb, simm, res, daddr, nxt, got;
    logic        ok, wreg, has_mem, is_st;
    int n;
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21] % NREGS; rt = ins[20:16] % NREGS; rd = ins[15:11] % NREGS;
    va = rregs[rs]; vb = rregs[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    nxt = mpc + 4; ok = 1'b1; wreg = 1'b0; has_mem = 1'b0; is_st = 1'b0;
    base = 4; res = '0; dest = 0; daddr = '0;
    case (op)
      6'h00: begin
        wreg = 1'b1; dest = rd;
        case (fn)
          6'h20: res = va + vb;
          6'h22: res = va - vb;
          6'h24: res = va & vb;
          6'h25: res = va | vb;
          6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          default: ok = 1'b0;
        endcase
      end
      6'h08: begin wreg = 1'b1; dest = rt; res = va + simm; end
      6'h23: begin has_mem = 1'b1; base = 5; wreg = 1'b1; dest = rt; daddr = va + simm; end
      6'h2B: begin has_mem = 1'b1; is_st = 1'b1; daddr = va + simm; end
      6'h04: begin base = 3; if (va == vb) nxt = mpc + 4 + (simm << 2); end
      6'h02: begin base = 3; nxt = {nxt[31:28], ins[25:0], 2'b00}; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin base = 2; wreg = 1'b0; has_mem = 1'b0; end

    mem[mpc[11:2]] = ins;
    total_lat = 0;
    serve("fetch", mpc, 1'b0, 1'b0, '0, 3'd0, got);
    if (has_mem) begin
      serve(is_st ? "store" : "load", {daddr[31:2], 2'b00}, is_st, is_st, vb, 3'd3, got);
      if (is_st) rdmem[daddr[11:2]] = vb;
      else       res = rdmem[daddr[11:2]];
    end
    n = 0;
    while (retire !== 1'b1 && illegal !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("retire", retire, ok);
    check("illegal", illegal, !ok);
    check("cycles", cyc - t_prev, base + total_lat);
    t_prev = cyc;
    if (wreg && dest != 0) rregs[dest] = res;
    if (ok) nretired++;
`ifdef MC_DP_PERF_EN
    check("perf_retired", perf_retired, nretired);
    check("perf_cycles", perf_cycles, cyc - t_rel);
`endif
    mpc = nxt;
  endtask

  task automatic gen(output logic [31:0] ins);
    int unsigned kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  op, fn;
    logic [31:0] tgt, diff;
    logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    kind = (mpc >= 32'h7F0) ? 7 : $urandom_range(0, 9);
    case (kind)
      0, 1: ins = enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]);
      2, 9: ins = enc_i(6'h08, rs, rt, 16'($urandom));
      3, 4, 5: begin
        tgt  = 32'h800 + 4 * $urandom_range(0, 511);
        diff = tgt - rregs[rs % NREGS];
        if (!(diff[31:15] == '0 || diff[31:15] == '1)) begin
          rs = 5'd0;
          diff = tgt;
        end
        ins = enc_i((kind == 3) ? 6'h23 : 6'h2B, rs, rt, diff[15:0]);
      end
      6: begin
        if ($urandom_range(0, 1) == 1) rt = rs;
        tgt  = $urandom_range(0, 511);
        diff = tgt - (mpc / 4 + 1);
        ins  = enc_i(6'h04, rs, rt, diff[15:0]);
      end
      7: ins = {6'h02, 26'($urandom_range(0, 511))};
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          do op = 6'($urandom); while (op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B});
          ins = {op, 26'($urandom)};
        end else begin
          do fn = 6'($urandom); while (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
          ins = enc_r(rs, rt, rd, fn);
        end
      end
    endcase
  endtask

  task automatic abort_test();
    logic [31:0] got;
    int n = 0;
    mem[mpc[11:2]] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0900);
    total_lat = 0;
    serve("abort_fetch", mpc, 1'b0, 1'b0, '0, 3'd0, got);
    while (mem_req !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("abort_mem_req", mem_req, 1'b1);
    check("abort_mem_state", state_dbg, 3'd3);
    #1 rst_n = 1'b0;
    #1;
    check("abort_req_drop", mem_req, 1'b0);
    check("abort_we_drop", mem_we, 1'b0);
    check("abort_addr_zero", mem_addr, 32'd0);
    check("abort_state", state_dbg, 3'd0);
    mem_rdata = 32'hDEAD_BEEF;
    mem_ack   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("abort_retire", retire, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) rregs[i] = '0;
    mpc = RESET_PC; t_prev = cyc; t_rel = cyc; nretired = 0;
    #1;
    check("abort_rel_req", mem_req, 1'b1);
    check("abort_rel_addr", mem_addr, RESET_PC);
  endtask

  initial begin
    logic [31:0] ins;
    for (int i = 0; i < 1024; i++) begin
      ins = $urandom;
      mem[i] = ins;
      rdmem[i] = ins;
    end
    for (int i = 0; i < 32; i++) rregs[i] = '0;
    mpc = RESET_PC; lat_max = 0; nretired = 0;
    repeat (3) @(negedge clk);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_retire", retire, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_state", state_dbg, 3'd0);
    rst_n = 1'b1;
    t_prev = cyc; t_rel = cyc;
    #1;
    check("rel_req", mem_req, 1'b1);
    check("rel_addr", mem_addr, RESET_PC);

    run_instr(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    run_instr(enc_i(6'h08, 5'd0, 5'd2, 16'd7));
    run_instr(enc_r(5'd1, 5'd2, 5'd3, 6'h20));
    run_instr(enc_i(6'h2B, 5'd0, 5'd3, 16'h0810));
    run_instr(enc_i(6'h23, 5'd0, 5'd4, 16'h0810));
    run_instr(enc_i(6'h2B, 5'd0, 5'd4, 16'h0814));
    run_instr(enc_i(6'h08, 5'd0, 5'd0, 16'd9));
    run_instr(enc_i(6'h2B, 5'd0, 5'd0, 16'h0818));
    run_instr(32'hFC00_0000);
    run_instr(enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF));
    run_instr(enc_i(6'h04, 5'd1, 5'd2, 16'hFFFF));
    run_instr(enc_r(5'd2, 5'd1, 5'd5, 6'h2A));
    run_instr(enc_i(6'h2B, 5'd0, 5'd5, 16'h081C));
    run_instr({6'h02, 26'h40});

    lat_max = 2;
    repeat (250) begin
      gen(ins);
      run_instr(ins);
    end
    abort_test();
    repeat (100) begin
      gen(ins);
      run_instr(ins);
    end
    run_instr({6'h02, 26'd0});
    for (int unsigned r = 1; r < NREGS; r++)
      run_instr(enc_i(6'h2B, 5'd0, 5'(r), 16'(32'hC00 + 4 * r)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
